// File: rtl/clk_gate_ctrl.sv
// rtl/clk_gate_ctrl.sv - per-domain ICG enable sequencer: ON, idle hysteresis, quiesce, gate off, timed wake
module clk_gate_ctrl #(
  parameter int N_DOM    = 4,
  parameter int IDLE_CYC = 16,
  parameter int WAKE_CYC = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             test_en,
  input  logic [N_DOM-1:0] gate_allow,
  input  logic [N_DOM-1:0] dom_busy,
  input  logic [N_DOM-1:0] wake_req,
  input  logic [N_DOM-1:0] quiesce_ack,
  output logic [N_DOM-1:0] quiesce_req,
  output logic [N_DOM-1:0] icg_en,
  output logic [N_DOM-1:0] dom_ready
);

  localparam int CNT_W = $clog2(IDLE_CYC + 1);
  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYC - 1);
  localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_CYC - 1);

  typedef enum logic [1:0] {ST_ON, ST_DRAIN, ST_OFF, ST_WAKE} state_e;

  state_e           state_q [N_DOM];
  state_e           state_d [N_DOM];
  logic [CNT_W-1:0] cnt_q   [N_DOM];
  logic [CNT_W-1:0] cnt_d   [N_DOM];
  logic [N_DOM-1:0] idle;
  logic [N_DOM-1:0] icg_en_q, dom_ready_q, quiesce_req_q;

  assign idle = gate_allow & ~dom_busy & ~wake_req & {N_DOM{~test_en}};

  always_comb begin
    for (int i = 0; i < N_DOM; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      unique case (state_q[i])
        ST_ON: begin
          if (!idle[i]) begin
            cnt_d[i] = '0;
          end else if (cnt_q[i] == IDLE_LAST) begin
            state_d[i] = ST_DRAIN;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] != '1) begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end
        ST_DRAIN: begin
          // Loss of idleness outranks an ack arriving on the same edge.
          cnt_d[i] = '0;
          if (!idle[i])             state_d[i] = ST_ON;
          else if (quiesce_ack[i])  state_d[i] = ST_OFF;
        end
        ST_OFF: begin
          cnt_d[i] = '0;
          if (wake_req[i] | dom_busy[i] | ~gate_allow[i] | test_en) state_d[i] = ST_WAKE;
        end
        ST_WAKE: begin
          if (cnt_q[i] == WAKE_LAST) begin
            state_d[i] = ST_ON;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end
        default: begin
          state_d[i] = ST_ON;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_DOM; i++) begin
        state_q[i] <= ST_ON;
        cnt_q[i]   <= '0;
      end
      icg_en_q      <= '1;
      dom_ready_q   <= '1;
      quiesce_req_q <= '0;
    end else begin
      // Outputs decode the next state so they line up with the state register.
      for (int i = 0; i < N_DOM; i++) begin
        state_q[i]       <= state_d[i];
        cnt_q[i]         <= cnt_d[i];
        icg_en_q[i]      <= (state_d[i] != ST_OFF);
        dom_ready_q[i]   <= (state_d[i] == ST_ON);
        quiesce_req_q[i] <= (state_d[i] == ST_DRAIN);
      end
    end
  end

  assign icg_en      = icg_en_q;
  assign dom_ready   = dom_ready_q;
  assign quiesce_req = quiesce_req_q;

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// tb/tb_clk_gate_ctrl.sv - randomized bench for clk_gate_ctrl against a behavioural gating model
module tb_clk_gate_ctrl;
  localparam int N    = 4;
  localparam int IDLE = 16;
  localparam int WAKE = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         test_en;
  logic [N-1:0] gate_allow, dom_busy, wake_req, quiesce_ack;
  logic [N-1:0] quiesce_req, icg_en, dom_ready;

  clk_gate_ctrl #(.N_DOM(N), .IDLE_CYC(IDLE), .WAKE_CYC(WAKE)) dut (
    .clk(clk), .rst_n(rst_n), .test_en(test_en), .gate_allow(gate_allow),
    .dom_busy(dom_busy), .wake_req(wake_req), .quiesce_ack(quiesce_ack),
    .quiesce_req(quiesce_req), .icg_en(icg_en), .dom_ready(dom_ready)
  );

  always #5 clk = ~clk;

  // Model: idle run length, outstanding quiesce request, gated flag, remaining wake cycles.
  int n_tests = 0;
  int n_fail  = 0;
  int run_m  [N];
  bit req_m  [N];
  bit gated_m[N];
  int wake_m [N];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      run_m[i] = 0; req_m[i] = 0; gated_m[i] = 0; wake_m[i] = 0;
    end
  endtask

  task automatic model_step();
    bit idle;
    for (int i = 0; i < N; i++) begin
      idle = gate_allow[i] & ~dom_busy[i] & ~wake_req[i] & ~test_en;
      if (gated_m[i]) begin
        if (wake_req[i] | dom_busy[i] | ~gate_allow[i] | test_en) begin
          gated_m[i] = 0;
          wake_m[i]  = WAKE;
        end
      end else if (wake_m[i] > 0) begin
        wake_m[i]--;
      end else if (req_m[i]) begin
        if (!idle) begin
          req_m[i] = 0; run_m[i] = 0;
        end else if (quiesce_ack[i]) begin
          req_m[i] = 0; gated_m[i] = 1;
        end
      end else if (idle) begin
        run_m[i]++;
        if (run_m[i] == IDLE) begin
          req_m[i] = 1; run_m[i] = 0;
        end
      end else begin
        run_m[i] = 0;
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [N-1:0] e_icg, e_rdy, e_req;
    for (int i = 0; i < N; i++) begin
      e_icg[i] = ~gated_m[i];
      e_req[i] = req_m[i];
      e_rdy[i] = ~gated_m[i] & ~req_m[i] & (wake_m[i] == 0);
    end
    chk({tag, ".icg_en"}, 32'(icg_en), 32'(e_icg));
    chk({tag, ".dom_ready"}, 32'(dom_ready), 32'(e_rdy));
    chk({tag, ".quiesce_req"}, 32'(quiesce_req), 32'(e_req));
  endtask

  // Inputs are already set (just after a negedge); advance one edge and compare.
  task automatic cycle(input string tag);
    model_step();
    @(negedge clk);
    check_outputs(tag);
  endtask

  task automatic drive_rand(input int busy_w, input int wake_w, input int test_w, input int ack_w);
    for (int i = 0; i < N; i++) begin
      gate_allow[i]  = ($urandom_range(0, 15) != 0);
      dom_busy[i]    = ($urandom_range(0, busy_w - 1) == 0);
      wake_req[i]    = ($urandom_range(0, wake_w - 1) == 0);
      quiesce_ack[i] = ($urandom_range(0, ack_w - 1) == 0);
    end
    test_en = ($urandom_range(0, test_w - 1) == 0);
  endtask

  task automatic quiet_with_ack();
    gate_allow = '1; dom_busy = '0; wake_req = '0; test_en = 1'b0;
    for (int i = 0; i < N; i++) quiesce_ack[i] = req_m[i];
  endtask

  initial begin
    rst_n = 1'b0; test_en = 1'b0;
    gate_allow = '0; dom_busy = '0; wake_req = '0; quiesce_ack = '0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset.icg_en", 32'(icg_en), 32'hF);
    chk("reset.dom_ready", 32'(dom_ready), 32'hF);
    chk("reset.quiesce_req", 32'(quiesce_req), 32'h0);
    rst_n = 1'b1;
    repeat (30) cycle("hold");

    // Gate everything off with ack echoing the request, then force a wake via test mode.
    repeat (40) begin quiet_with_ack(); cycle("gate_all"); end
    chk("all_off.icg_en", 32'(icg_en), 32'h0);
    test_en = 1'b1; quiesce_ack = '0;
    cycle("test_wake");
    chk("test_wake.icg_en", 32'(icg_en), 32'hF);
    chk("test_wake.dom_ready", 32'(dom_ready), 32'h0);
    repeat (WAKE) cycle("test_hold");
    chk("test_done.dom_ready", 32'(dom_ready), 32'hF);
    repeat (5) cycle("test_hold");

    // Gate off again, pulse wake_req on domain 2, then reset asynchronously mid-WAKE.
    repeat (40) begin quiet_with_ack(); cycle("regate"); end
    quiet_with_ack(); wake_req[2] = 1'b1;
    cycle("wake2");
    chk("wake2.icg_en", 32'(icg_en), 32'h4);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("async_rst");
    @(negedge clk);
    rst_n = 1'b1; wake_req = '0;

    for (int ph = 0; ph < 4; ph++) begin
      repeat (700) begin
        case (ph)
          0: drive_rand(64, 128, 256, 3);
          1: drive_rand(16, 32, 64, 2);
          2: drive_rand(4, 8, 32, 1);
          default: drive_rand(32, 16, 16, 4);
        endcase
        cycle($sformatf("rand%0d", ph));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
